lsu_rv32: RTL and testbench
===========================

LSU_RV32 -- requirements
Module: lsu_rv32

Interface
REQ-001 Parameter AddrWidth, default 14, SHALL set the byte-address width of the data memory (2**AddrWidth bytes).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 req_valid  input  1  SHALL indicate a load/store request from the core.
REQ-005 req_ready  output  1  SHALL indicate the LSU accepts a request; a request is accepted when req_valid && req_ready.
REQ-006 req_we  input  1  SHALL select store (1) or load (0).
REQ-007 req_funct3  input  3  SHALL carry the width/sign code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 req_addr  input  32  SHALL be the byte address.
REQ-009 req_wdata  input  32  SHALL be the store data, right-justified.
REQ-010 resp_valid  output  1  SHALL pulse for exactly one cycle per accepted request.
REQ-011 resp_rdata  output  32  SHALL be the extended load data, valid with resp_valid; 0 for stores and errors.
REQ-012 resp_err  output  1  SHALL flag an illegal request, valid with resp_valid.
REQ-013 mem_valid  output  1  SHALL request a memory word access; held until mem_valid && mem_ready.
REQ-014 mem_ready  input  1  SHALL accept the memory request.
REQ-015 mem_we  output  1  SHALL mark the memory access as a write.
REQ-016 mem_addr  output  AddrWidth  SHALL be the word-aligned byte address (bits [1:0] = 0).
REQ-017 mem_be  output  4  SHALL be the byte enables of the access.
REQ-018 mem_wdata  output  32  SHALL be the lane-aligned write data.
REQ-019 mem_rvalid  input  1  SHALL mark mem_rdata valid for the oldest outstanding read.
REQ-020 mem_rdata  input  32  SHALL be the read word.

Function
REQ-021 FSM states SHALL be IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP; req_ready=1 only in IDLE.
REQ-022 On acceptance, addr, we, funct3 and wdata SHALL be registered; next state ACC0, or RESP with resp_err=1 if illegal.
REQ-023 Illegal = funct3 not in the REQ-007 set for its direction, or req_addr[31:AddrWidth] != 0, or misalignment per Configuration; no memory access SHALL occur for an illegal request.
REQ-024 In ACC0/ACC1, mem_valid=1; on handshake, reads go to WAIT0/WAIT1, writes go to ACC1 if a second beat is needed else RESP.
REQ-025 In WAIT0/WAIT1, mem_rvalid SHALL capture the needed bytes; then ACC1 if a second beat is needed else RESP.
REQ-026 Byte offset o=addr[1:0]; beat-0 mem_be = size mask (0001/0011/1111) shifted left by o, truncated to 4 bits; mem_wdata = wdata << 8*o.
REQ-027 Beat 1 SHALL use mem_addr + 4, mem_be = remaining low lanes, mem_wdata = wdata >> 8*(4-o).
REQ-028 Load data SHALL be reassembled from both beats, shifted to bit 0, sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-029 RESP SHALL assert resp_valid for one cycle, then return to IDLE; aligned load latency = one cycle after mem_rvalid; aligned store = one cycle after mem_ready handshake.
REQ-030 A memory address beyond 2**AddrWidth-1 on beat 1 SHALL wrap to 0.

Reset
REQ-031 While rst=1, state SHALL be IDLE, and req_ready, resp_valid, resp_err, mem_valid, mem_we SHALL be 0; resp_rdata, mem_addr, mem_be and mem_wdata SHALL be 0.
REQ-032 rst asserted mid-transaction SHALL abandon it with no resp_valid; a later mem_rvalid SHALL be ignored.

Configuration
REQ-033 With MISALIGNED_SPLIT_EN defined, misaligned accesses SHALL be legal: within-word accesses use one beat, word-crossing accesses (LH/SH at o=3, LW/SW at o!=0) use two beats.
REQ-034 Without MISALIGNED_SPLIT_EN, any access with o not a multiple of its size SHALL be illegal, and ACC1/WAIT1 SHALL be unreachable.

Verification
REQ-035 SW addr 0x10, wdata 0xDEADBEEF, mem_ready=1 -> mem_addr 0x10, mem_be 1111, mem_wdata 0xDEADBEEF; resp_valid one cycle later, resp_err 0.
REQ-036 LB addr 0x13, mem_rdata 0x80FFFFFF -> mem_be 1000, resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 LW addr 0x11 -> with MISALIGNED_SPLIT_EN: beats 0x10 (be 1110) and 0x14 (be 0001), rdata 0x44332211/0x88776655 -> resp_rdata 0x55443322; without: resp_err 1, mem_valid never asserted.
REQ-038 Load with req_funct3=011 or req_addr=0x0001_0000 (AddrWidth 14) -> resp_err 1, resp_rdata 0, no memory access.
REQ-039 mem_ready held 0 for 5 cycles -> mem_valid, mem_addr, mem_be, mem_wdata stable; req_ready 0 throughout.
REQ-040 rst pulsed in WAIT0, then mem_rvalid -> no resp_valid; next LW addr 0x20 completes normally.

Source files
------------

// File: rtl/lsu_rv32_if.sv
// lsu_rv32_if: bundles the core-side request/response handshake and the
// word-oriented memory port of the RV32 load/store unit.
//
// Parameter:
//   AddrWidth  byte-address width of the data memory
// Modports:
//   slave   - the LSU view: takes core requests, drives responses, and
//             drives the memory request side while taking memory replies
//   master  - the environment view: the core issuing requests plus the
//             memory answering them
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//   resp_valid/resp_rdata/resp_err                            core response
//   mem_valid/mem_ready/mem_we/mem_addr/mem_be/mem_wdata      memory request
//   mem_rvalid/mem_rdata                                      memory read reply
interface lsu_rv32_if #(
  parameter int AddrWidth = 14
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic                 resp_err;
  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [3:0]           mem_be;
  logic [31:0]          mem_wdata;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_rv32.sv
// lsu_rv32: RV32 load/store unit. Accepts one byte/half/word load or store
// from the core, turns it into one (or, for word-crossing accesses, two)
// word-aligned memory beats with byte enables, reassembles and extends load
// data, and returns a single-cycle response.
//
// Parameter:
//   AddrWidth  byte-address width of the data memory (2**AddrWidth bytes)
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   lsu_rv32_if.slave - core request/response and memory port
//
// Build option:
//   MISALIGNED_SPLIT_EN  when defined, misaligned accesses are legal; those
//                        crossing a word boundary are split into two beats.
//                        When undefined, misaligned accesses return resp_err.
module lsu_rv32 #(
  parameter int AddrWidth = 14
) (
  input  logic      clk,
  input  logic      rst,
  lsu_rv32_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC0  = 3'd1,
    WAIT0 = 3'd2,
    ACC1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [AddrWidth-1:0] WordStep = AddrWidth'(3'd4);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [AddrWidth-1:0] addr_r;
  logic                 we_r;
  logic [2:0]           funct3_r;
  logic [31:0]          wdata_r;
  logic                 err_r;
  // bytes 0..3 from beat 0, bytes 4..6 from beat 1 (byte 7 is never needed)
  logic [55:0]          raw_r;

  logic                 misalign_err_s;
  logic                 illegal_s;
  logic [1:0]           off_s;
  logic [7:0]           be_full_s;
  logic [63:0]          wdata_full_s;
  logic [AddrWidth-1:0] base_addr_s;
  logic                 two_beat_s;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = ~we;
      default:                funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      default: size_mask = 8'h0F;
    endcase
  endfunction

  // Shift the two captured beats so the addressed byte lands at bit 0.
  function automatic logic [31:0] align_load(input logic [55:0] raw, input logic [1:0] off);
    case (off)
      2'b00:   align_load = raw[31:0];
      2'b01:   align_load = raw[39:8];
      2'b10:   align_load = raw[47:16];
      2'b11:   align_load = raw[55:24];
      default: align_load = raw[31:0];
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  extend_load = {{24{v[7]}}, v[7:0]};
      3'b001:  extend_load = {{16{v[15]}}, v[15:0]};
      3'b100:  extend_load = {24'd0, v[7:0]};
      3'b101:  extend_load = {16'd0, v[15:0]};
      default: extend_load = v;
    endcase
  endfunction

  // Legality of the incoming request (decoded before it is registered).
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    misalign_err_s = 1'b0;
`else
    case (bus.req_funct3[1:0])
      2'b01:   misalign_err_s = bus.req_addr[0];
      2'b10:   misalign_err_s = (bus.req_addr[1:0] != 2'b00);
      default: misalign_err_s = 1'b0;
    endcase
`endif
    illegal_s = ~funct3_legal(bus.req_we, bus.req_funct3)
              | ((bus.req_addr >> AddrWidth) != 32'd0)
              | misalign_err_s;
  end

  // Lane placement for both beats: the low nibble/word is beat 0, the high
  // nibble/word spills into beat 1 at the next word address.
  always_comb begin
    off_s        = addr_r[1:0];
    be_full_s    = size_mask(funct3_r[1:0]) << off_s;
    wdata_full_s = {32'd0, wdata_r} << {off_s, 3'b000};
    base_addr_s  = {addr_r[AddrWidth-1:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
    two_beat_s   = (be_full_s[7:4] != 4'b0000);
`else
    two_beat_s   = 1'b0;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = illegal_s ? RESP : ACC0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACC0: begin
        if (bus.mem_ready) begin
          if (we_r) begin
            state_nxt_s = two_beat_s ? ACC1 : RESP;
          end else begin
            state_nxt_s = WAIT0;
          end
        end else begin
          state_nxt_s = ACC0;
        end
      end
      WAIT0: begin
        if (bus.mem_rvalid) begin
          state_nxt_s = two_beat_s ? ACC1 : RESP;
        end else begin
          state_nxt_s = WAIT0;
        end
      end
      ACC1: begin
        if (bus.mem_ready) begin
          state_nxt_s = we_r ? RESP : WAIT1;
        end else begin
          state_nxt_s = ACC1;
        end
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT1;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from registered state; forced quiet while rst is high.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_valid  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = 4'b0000;
    bus.mem_wdata  = 32'd0;
    if (rst) begin
      bus.req_ready = 1'b0;
    end else begin
      case (state_r)
        IDLE: bus.req_ready = 1'b1;
        ACC0: begin
          bus.mem_valid = 1'b1;
          bus.mem_we    = we_r;
          bus.mem_addr  = base_addr_s;
          bus.mem_be    = be_full_s[3:0];
          bus.mem_wdata = wdata_full_s[31:0];
        end
        ACC1: begin
          bus.mem_valid = 1'b1;
          bus.mem_we    = we_r;
          bus.mem_addr  = base_addr_s + WordStep;  // wraps at 2**AddrWidth
          bus.mem_be    = be_full_s[7:4];
          bus.mem_wdata = wdata_full_s[63:32];
        end
        RESP: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_r;
          bus.resp_rdata = (we_r | err_r) ? 32'd0
                         : extend_load(funct3_r, align_load(raw_r, off_s));
        end
        default: bus.req_ready = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture and read-beat collection.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r   <= '0;
      we_r     <= 1'b0;
      funct3_r <= 3'b000;
      wdata_r  <= 32'd0;
      err_r    <= 1'b0;
      raw_r    <= 56'd0;
    end else begin
      if (state_r == IDLE && bus.req_valid) begin
        addr_r   <= bus.req_addr[AddrWidth-1:0];
        we_r     <= bus.req_we;
        funct3_r <= bus.req_funct3;
        wdata_r  <= bus.req_wdata;
        err_r    <= illegal_s;
        raw_r    <= 56'd0;
      end
      if (state_r == WAIT0 && bus.mem_rvalid) begin
        raw_r[31:0] <= bus.mem_rdata;
      end
      if (state_r == WAIT1 && bus.mem_rvalid) begin
        raw_r[55:32] <= bus.mem_rdata[23:0];
      end
    end
  end

endmodule

// File: tb/tb_lsu_rv32.sv
// tb_lsu_rv32: directed self-checking bench for lsu_rv32. A small memory
// responder answers mem requests (optionally stalling, optionally replying
// to reads by hand) and logs every accepted beat; the main sequence issues
// requests and compares against hand-computed values.
module tb_lsu_rv32;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_rv32_if #(.AddrWidth(AW)) bus ();
  lsu_rv32 #(.AddrWidth(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem [16];
  int          stall_cycles = 0;
  logic        auto_rvalid = 1'b1;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'd0;
  logic [31:0] beat_addr_q [$];
  logic [31:0] beat_be_q [$];
  logic [31:0] beat_wd_q [$];
  logic [31:0] beat_we_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input logic we);
    if (idx < beat_addr_q.size()) begin
      check({tag, "_addr"}, beat_addr_q[idx], a);
      check({tag, "_be"}, beat_be_q[idx], 32'(be));
      check({tag, "_we"}, beat_we_q[idx], 32'(we));
      if (we) check({tag, "_wdata"}, beat_wd_q[idx], wd);
    end else begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int base);
    @(negedge clk);
    base = beat_addr_q.size();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_wdata  = 32'd0;
    rdata = 32'd0;
    err   = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (bus.resp_valid) begin
        lat   = i;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
    if (lat == 0) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
    end
  endtask

  // Memory responder: ready after stall_cycles of mem_valid, read data one
  // cycle after the handshake.
  initial begin
    logic       rd_pending;
    logic [3:0] rd_idx;
    int         hs_wait;
    rd_pending = 1'b0;
    rd_idx     = 4'd0;
    hs_wait    = 0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (auto_rvalid) begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        if (rd_pending) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem[rd_idx];
          rd_pending     = 1'b0;
        end
      end else begin
        bus.mem_rvalid = man_rvalid;
        bus.mem_rdata  = man_rdata;
      end
      bus.mem_ready = 1'b0;
      if (bus.mem_valid && !rst) begin
        if (hs_wait < stall_cycles) begin
          hs_wait++;
        end else begin
          hs_wait = 0;
          bus.mem_ready = 1'b1;
          beat_addr_q.push_back(32'(bus.mem_addr));
          beat_be_q.push_back(32'(bus.mem_be));
          beat_wd_q.push_back(bus.mem_wdata);
          beat_we_q.push_back(32'(bus.mem_we));
          if (!bus.mem_we && auto_rvalid) begin
            rd_pending = 1'b1;
            rd_idx     = bus.mem_addr[5:2];
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          base;
    int          found;
    logic        seen;

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_be", 32'(bus.mem_be), 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // Aligned SW
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, base);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_beats", 32'(beat_addr_q.size() - base), 32'd1);
    check_beat("sw_b0", base, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b1);

    // Byte / half loads with sign and zero extension
    mem[4] = 32'h80FFFFFF;
    do_req(1'b0, 3'b000, 32'h13, 32'd0, rd, er, lat, base);
    check("lb_rdata", rd, 32'hFFFFFF80);
    check("lb_err", 32'(er), 32'd0);
    check("lb_latency", 32'(lat), 32'd3);
    check_beat("lb_b0", base, 32'h10, 4'b1000, 32'd0, 1'b0);
    do_req(1'b0, 3'b100, 32'h13, 32'd0, rd, er, lat, base);
    check("lbu_rdata", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h12, 32'd0, rd, er, lat, base);
    check("lh_rdata", rd, 32'hFFFF80FF);
    check_beat("lh_b0", base, 32'h10, 4'b1100, 32'd0, 1'b0);
    do_req(1'b0, 3'b101, 32'h12, 32'd0, rd, er, lat, base);
    check("lhu_rdata", rd, 32'h000080FF);

    // Sub-word stores: lane placement
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AB, rd, er, lat, base);
    check("sb_err", 32'(er), 32'd0);
    check_beat("sb_b0", base, 32'h20, 4'b0010, 32'h0000AB00, 1'b1);
    do_req(1'b1, 3'b001, 32'h22, 32'h00001234, rd, er, lat, base);
    check_beat("sh_b0", base, 32'h20, 4'b1100, 32'h12340000, 1'b1);

    // Misaligned accesses
    mem[4]  = 32'h44332211;
    mem[5]  = 32'h88776655;
    mem[15] = 32'hA1B2C3D4;
    mem[0]  = 32'h000000E5;
`ifdef MISALIGNED_SPLIT_EN
    do_req(1'b0, 3'b010, 32'h11, 32'd0, rd, er, lat, base);
    check("lw_mis_err", 32'(er), 32'd0);
    check("lw_mis_rdata", rd, 32'h55443322);
    check("lw_mis_latency", 32'(lat), 32'd5);
    check("lw_mis_beats", 32'(beat_addr_q.size() - base), 32'd2);
    check_beat("lw_mis_b0", base, 32'h10, 4'b1110, 32'd0, 1'b0);
    check_beat("lw_mis_b1", base + 1, 32'h14, 4'b0001, 32'd0, 1'b0);
    do_req(1'b0, 3'b001, 32'h11, 32'd0, rd, er, lat, base);
    check("lh_mis_rdata", rd, 32'h00003322);
    check("lh_mis_beats", 32'(beat_addr_q.size() - base), 32'd1);
    check_beat("lh_mis_b0", base, 32'h10, 4'b0110, 32'd0, 1'b0);
    do_req(1'b1, 3'b010, 32'h13, 32'hAABBCCDD, rd, er, lat, base);
    check("sw_mis_err", 32'(er), 32'd0);
    check("sw_mis_latency", 32'(lat), 32'd3);
    check_beat("sw_mis_b0", base, 32'h10, 4'b1000, 32'hDD000000, 1'b1);
    check_beat("sw_mis_b1", base + 1, 32'h14, 4'b0111, 32'h00AABBCC, 1'b1);
    do_req(1'b0, 3'b010, 32'h3FFD, 32'd0, rd, er, lat, base);
    check("lw_wrap_rdata", rd, 32'hE5A1B2C3);
    check_beat("lw_wrap_b0", base, 32'h3FFC, 4'b1110, 32'd0, 1'b0);
    check_beat("lw_wrap_b1", base + 1, 32'h0000, 4'b0001, 32'd0, 1'b0);
`else
    do_req(1'b0, 3'b010, 32'h11, 32'd0, rd, er, lat, base);
    check("lw_mis_err", 32'(er), 32'd1);
    check("lw_mis_rdata", rd, 32'd0);
    check("lw_mis_latency", 32'(lat), 32'd1);
    check("lw_mis_beats", 32'(beat_addr_q.size() - base), 32'd0);
    do_req(1'b0, 3'b001, 32'h11, 32'd0, rd, er, lat, base);
    check("lh_mis_err", 32'(er), 32'd1);
    do_req(1'b1, 3'b010, 32'h13, 32'hAABBCCDD, rd, er, lat, base);
    check("sw_mis_err", 32'(er), 32'd1);
    check("sw_mis_beats", 32'(beat_addr_q.size() - base), 32'd0);
    do_req(1'b0, 3'b010, 32'h3FFD, 32'd0, rd, er, lat, base);
    check("lw_wrap_err", 32'(er), 32'd1);
`endif

    // Illegal requests
    do_req(1'b0, 3'b011, 32'h10, 32'd0, rd, er, lat, base);
    check("f3_011_err", 32'(er), 32'd1);
    check("f3_011_rdata", rd, 32'd0);
    check("f3_011_latency", 32'(lat), 32'd1);
    check("f3_011_beats", 32'(beat_addr_q.size() - base), 32'd0);
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'd0, rd, er, lat, base);
    check("oor_err", 32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    check("oor_beats", 32'(beat_addr_q.size() - base), 32'd0);
    do_req(1'b0, 3'b010, 32'h0000_4000, 32'd0, rd, er, lat, base);
    check("oor_edge_err", 32'(er), 32'd1);
    do_req(1'b1, 3'b100, 32'h20, 32'h55, rd, er, lat, base);
    check("sbu_err", 32'(er), 32'd1);
    check("sbu_beats", 32'(beat_addr_q.size() - base), 32'd0);

    // Memory back-pressure: request must hold steady
    stall_cycles = 5;
    @(negedge clk);
    base = beat_addr_q.size();
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h24;
    bus.req_wdata  = 32'h01020304;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_mem_valid", 32'(bus.mem_valid), 32'd1);
      check("stall_mem_addr", 32'(bus.mem_addr), 32'h24);
      check("stall_mem_be", 32'(bus.mem_be), 32'hF);
      check("stall_mem_wdata", bus.mem_wdata, 32'h01020304);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        found = 1;
        check("stall_err", 32'(bus.resp_err), 32'd0);
        break;
      end
    end
    check("stall_resp_seen", 32'(found), 32'd1);
    check("stall_beats", 32'(beat_addr_q.size() - base), 32'd1);
    stall_cycles = 0;

    // Reset in WAIT0, then a stale mem_rvalid
    auto_rvalid = 1'b0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    man_rdata  = 32'h12345678;
    man_rvalid = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = bus.resp_valid;
    @(posedge clk);
    man_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("rst_mid_no_resp", 32'(seen), 32'd0);
    check("rst_mid_idle", 32'(bus.req_ready), 32'd1);
    auto_rvalid = 1'b1;
    mem[8] = 32'hCAFEF00D;
    do_req(1'b0, 3'b010, 32'h20, 32'd0, rd, er, lat, base);
    check("post_rst_rdata", rd, 32'hCAFEF00D);
    check("post_rst_err", 32'(er), 32'd0);
    check("post_rst_latency", 32'(lat), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
